// File: rtl/cnn_stream_pkg.sv
// Shared types and width helpers for the conv-layer streaming blocks.
package cnn_stream_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } stream_state_t;

  function automatic int unsigned addr_bits(input int unsigned side);
    return $clog2(side * side);
  endfunction

  function automatic int unsigned coord_bits(input int unsigned side);
    return $clog2(side);
  endfunction

endpackage

// File: rtl/ifm_window_streamer_if.sv
// IFM RAM read port plus line-buffer push and window-flag outputs.
interface ifm_window_streamer_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned IFM_SIZE   = 32
);
  localparam int unsigned ADDRESS_SIZE_IFM = cnn_stream_pkg::addr_bits(IFM_SIZE);
  localparam int unsigned COORD_BITS       = cnn_stream_pkg::coord_bits(IFM_SIZE);

  logic                        ifm_rd_en;
  logic [ADDRESS_SIZE_IFM-1:0] ifm_rd_addr;
  logic [DATA_WIDTH-1:0]       ifm_rd_data;
  logic                        fifo_enable;
  logic [DATA_WIDTH-1:0]       fifo_data_out;
  logic                        window_valid;
  logic [COORD_BITS-1:0]       out_row;
  logic [COORD_BITS-1:0]       out_col;

  modport master (
    output ifm_rd_en, ifm_rd_addr, fifo_enable, fifo_data_out,
    output window_valid, out_row, out_col,
    input  ifm_rd_data
  );

  modport slave (
    input  ifm_rd_en, ifm_rd_addr, fifo_enable, fifo_data_out,
    input  window_valid, out_row, out_col,
    output ifm_rd_data
  );
endinterface

// File: rtl/ifm_window_streamer_raster_position_counter.sv
// Row/column position in a SIZE x SIZE raster; col wraps into row.
module raster_position_counter #(
  parameter int unsigned SIZE       = 32,
  parameter int unsigned COORD_BITS = $clog2(SIZE)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  enable,
  output logic [COORD_BITS-1:0] row,
  output logic [COORD_BITS-1:0] col
);
  localparam logic [COORD_BITS-1:0] LAST = COORD_BITS'(SIZE - 1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row <= '0;
      col <= '0;
    end else if (clear) begin
      row <= '0;
      col <= '0;
    end else if (enable) begin
      if (col == LAST) begin
        col <= '0;
        row <= (row == LAST) ? '0 : row + COORD_BITS'(1);
      end else begin
        col <= col + COORD_BITS'(1);
      end
    end
  end
endmodule

// File: rtl/ifm_window_streamer.sv
// Streams one IFM channel from RAM into the line buffer and flags complete windows.
module ifm_window_streamer
  import cnn_stream_pkg::*;
#(
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned IFM_SIZE         = 32,
  parameter int unsigned KERNAL_SIZE      = 5,
  parameter int unsigned IFM_SIZE_NEXT    = IFM_SIZE - KERNAL_SIZE + 1,
  parameter int unsigned ADDRESS_SIZE_IFM = addr_bits(IFM_SIZE),
  parameter int unsigned COORD_BITS       = coord_bits(IFM_SIZE)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 hold,
  ifm_window_streamer_if.master bus,
  output logic                 busy,
  output logic                 done
);
  localparam logic [ADDRESS_SIZE_IFM-1:0] LAST_ADDR = ADDRESS_SIZE_IFM'(IFM_SIZE * IFM_SIZE - 1);
  localparam logic [COORD_BITS-1:0]       WIN_EDGE  = COORD_BITS'(IFM_SIZE - IFM_SIZE_NEXT);
  localparam logic [COORD_BITS-1:0]       TAP_OFS   = COORD_BITS'(KERNAL_SIZE - 1);

  stream_state_t               state, next_state;
  logic [ADDRESS_SIZE_IFM-1:0] rd_addr;
  logic                        drain_cnt;
  logic                        rd_en;
  logic                        start_accept;
  logic                        push_en;
  logic [DATA_WIDTH-1:0]       pixel_q;
  logic                        win_q;
  logic [COORD_BITS-1:0]       row_q, col_q;
  logic [COORD_BITS-1:0]       push_row, push_col;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = STREAM;
      STREAM:  if (!hold && rd_addr == LAST_ADDR) next_state = DRAIN;
      DRAIN:   if (drain_cnt) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    rd_en        = (state == STREAM) && !hold;
    start_accept = (state == IDLE) && start;
    busy         = (state == STREAM) || (state == DRAIN);
    done         = (state == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_addr   <= '0;
      drain_cnt <= 1'b0;
    end else begin
      if (start_accept || (rd_en && rd_addr == LAST_ADDR)) rd_addr <= '0;
      else if (rd_en)                                      rd_addr <= rd_addr + ADDRESS_SIZE_IFM'(1);
      drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
    end
  end

  // Taps update on the push edge, so the window flag trails the push by one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      push_en <= 1'b0;
      pixel_q <= '0;
      win_q   <= 1'b0;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      push_en <= rd_en;
      pixel_q <= bus.ifm_rd_data;
      win_q   <= push_en && (push_row >= WIN_EDGE) && (push_col >= WIN_EDGE);
      if (push_en && (push_row >= WIN_EDGE) && (push_col >= WIN_EDGE)) begin
        row_q <= push_row - TAP_OFS;
        col_q <= push_col - TAP_OFS;
      end
    end
  end

  raster_position_counter #(
    .SIZE       (IFM_SIZE),
    .COORD_BITS (COORD_BITS)
  ) u_push_pos (
    .clk    (clk),
    .reset  (reset),
    .clear  (start_accept),
    .enable (push_en),
    .row    (push_row),
    .col    (push_col)
  );

  assign bus.ifm_rd_en     = rd_en;
  assign bus.ifm_rd_addr   = rd_addr;
  assign bus.fifo_enable   = push_en;
  assign bus.fifo_data_out = pixel_q;
  assign bus.window_valid  = win_q;
  assign bus.out_row       = row_q;
  assign bus.out_col       = col_q;
endmodule

// File: doc/ifm_window_streamer.md
Name: ifm_window_streamer

Overview:
Producer side of the conv-layer sliding-window line buffer. On `start`, it reads one IFM channel (IFM_SIZE x IFM_SIZE, raster order) from IFM RAM and pushes one pixel per cycle into the 25-tap line buffer via `fifo_enable`/`fifo_data_out`. It also flags every cycle in which the buffer taps hold a complete KxK window (`window_valid`) and gives that window's output coordinates. The conv engine consumes those windows.

Parameters:
DATA_WIDTH, 32, pixel width
IFM_SIZE, 32, input feature-map side length
KERNAL_SIZE, 5, kernel side length
IFM_SIZE_NEXT, IFM_SIZE-KERNAL_SIZE+1, output side length (derived)
ADDRESS_SIZE_IFM, $clog2(IFM_SIZE*IFM_SIZE), IFM RAM address width (derived)
COORD_BITS, $clog2(IFM_SIZE), row/col counter width (derived)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low; 0 clears all state
start  in  1  one-cycle pulse; begin streaming one channel
hold  in  1  1 = do not issue a new RAM read this cycle
ifm_rd_en  out  1  IFM RAM read strobe
ifm_rd_addr  out  ADDRESS_SIZE_IFM  IFM RAM read address
ifm_rd_data  in  DATA_WIDTH  RAM data, valid 1 cycle after ifm_rd_en
fifo_enable  out  1  shift strobe to line buffer
fifo_data_out  out  DATA_WIDTH  pixel into line buffer
window_valid  out  1  line-buffer taps hold a complete window this cycle
out_row  out  COORD_BITS  output row of current window
out_col  out  COORD_BITS  output col of current window
busy  out  1  high from cycle after start until done
done  out  1  one-cycle pulse; channel fully streamed

Behaviour:
- Reset (reset=0, async): state IDLE. All outputs 0: ifm_rd_en, ifm_rd_addr, fifo_enable, fifo_data_out, window_valid, out_row, out_col, busy, done. All counters 0. Reset mid-stream aborts the channel; no done pulse.
- FSM states are IDLE, STREAM, DRAIN, DONE.
  - IDLE: start=1 -> STREAM, with rd_addr=0 and busy=1 next cycle.
  - STREAM: each cycle with hold=0, assert ifm_rd_en with ifm_rd_addr=rd_addr, then increment rd_addr. With hold=1, ifm_rd_en=0 and the address is held. When address IFM_SIZE^2-1 is issued -> DRAIN.
  - DRAIN: no reads; wait until the last pixel is pushed and its window_valid has been emitted (2 cycles) -> DONE. hold is ignored.
  - DONE: done=1 and busy=0 for one cycle -> IDLE.
- start while busy is ignored.
- Push path, registered:
  - fifo_enable(t+1) = ifm_rd_en(t)
  - fifo_data_out(t+1) = ifm_rd_data(t)
  - A read in flight when hold rises is still pushed.
- Position counters (push_row, push_col) track the pixel being pushed. push_col increments per push and wraps IFM_SIZE-1 -> 0, incrementing push_row. Both clear on start.
- window_valid is asserted the cycle after a push where push_row>=K-1 and push_col>=K-1, because the line-buffer taps update on that edge.
  - Registered alongside it: out_row = push_row-(K-1), out_col = push_col-(K-1).
  - Pushes with push_col<K-1 (row wrap-around) produce window_valid=0.
  - Exactly IFM_SIZE_NEXT^2 pulses per channel.
- Latency, no hold: start at cycle 0 -> first ifm_rd_en at 1 -> first fifo_enable at 2. First window_valid at 2+(K-1)*IFM_SIZE+(K-1)+1, which is cycle 135 for the defaults. Last window_valid in cycle IFM_SIZE^2+2, done one cycle later.
- The consumer must accept one window per cycle; there is no backpressure on window_valid. Throttle the stream with hold.
- The line buffer is not cleared between channels; windows are flagged only after a full refill, so stale data is never flagged.

Decomposition:
- Shared package (cnn_stream_pkg): FSM state enum (IDLE/STREAM/DRAIN/DONE, 2 bits) and width helper constants (ADDRESS_SIZE_IFM, COORD_BITS derivation).
- One sub-module, raster_position_counter: enable, clear, wrap at IFM_SIZE, outputs row/col. Instantiated once for push position. It is reusable by the conv-output writer.

Test Plan:
1. Defaults, start at cycle 0, hold=0, RAM returns data=address -> ifm_rd_addr 0..1023 on cycles 1..1024; fifo_data_out 0..1023 on cycles 2..1025. First window_valid at cycle 135 (row 0, col 0); 784 pulses total; last is (27,27) at cycle 1026; done at 1027.
2. Row wrap: same run -> window_valid=0 on the 4 cycles following pushes of cols 0..3 of each row ≥4. Windows (0,27) and (1,0) are separated by exactly 4 idle cycles.
3. hold=1 for cycles 50..59 -> no ifm_rd_en there, address 49 resumes at cycle 60. Pixel from cycle-49 read pushed at 50. 784 windows, done delayed by 10 cycles.
4. reset=0 asserted at cycle 300 for 2 cycles -> all outputs 0 immediately, no done. A new start completes a correct full channel (784 windows).
5. start pulses at cycle 500 while busy -> ignored; counts and done timing identical to scenario 1.
6. IFM_SIZE=6, KERNAL_SIZE=3 -> 16 window_valid pulses. First after push of pixel 14 (row 2, col 2) with out (0,0); last (3,3); done at cycle 39.
